mem_io_bus: RTL and testbench

Memory-and-peripheral subsystem directly downstream of the multicycle MIPS core. It consumes the core's adr/writedata/memwrite and returns readdata.
The address space is decoded into three regions: a unified instruction/data RAM, an LED output register, and a programmable timer with a sticky interrupt flag.
Reads are combinational, so the core's single-cycle memory timing is preserved. Writes commit on the clock edge.

---
 rtl/mem_io_pkg.sv | 40 ++++
 rtl/mem_io_bus_timer_unit.sv | 77 +++++++
 rtl/mem_io_bus.sv | 79 +++++++
 tb/tb_mem_io_bus.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// mem_io_pkg: address map, TCTRL bit positions and region decode shared by mem_io_bus.
`default_nettype none
package mem_io_pkg;

  localparam logic [31:0] LEDS_ADR   = 32'hFFFF_0000;
  localparam logic [31:0] TCOUNT_ADR = 32'hFFFF_0004;
  localparam logic [31:0] TCMP_ADR   = 32'hFFFF_0008;
  localparam logic [31:0] TCTRL_ADR  = 32'hFFFF_000C;

  localparam int EN_BIT     = 0;
  localparam int RELOAD_BIT = 1;
  localparam int STAT_BIT   = 2;

  // Timer register select is adr[3:2] within the timer window
  localparam logic [1:0] TREG_COUNT = 2'd1;
  localparam logic [1:0] TREG_CMP   = 2'd2;
  localparam logic [1:0] TREG_CTRL  = 2'd3;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_LEDS,
    SEL_TIMER,
    SEL_NONE
  } sel_t;

  function automatic sel_t decode(input logic [31:2] wadr);
    sel_t s;
    s = SEL_NONE;
    if (wadr[31:8] == 24'd0)
      s = SEL_RAM;
    else if (wadr == LEDS_ADR[31:2])
      s = SEL_LEDS;
    else if (wadr == TCOUNT_ADR[31:2] || wadr == TCMP_ADR[31:2] ||
             wadr == TCTRL_ADR[31:2])
      s = SEL_TIMER;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_io_bus_timer_unit.sv
// timer_unit: programmable up-counter with compare, one-shot/auto-reload and sticky W1C status.
`default_nettype none
module timer_unit
  import mem_io_pkg::*;
#(
  parameter int TIMER_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] writedata,
  output logic [31:0] count_rd,
  output logic [31:0] cmp_rd,
  output logic [31:0] ctrl_rd,
  output logic        timer_irq
);

  logic [TIMER_WIDTH-1:0] count;
  logic [TIMER_WIDTH-1:0] cmp;
  logic                   en;
  logic                   reload;
  logic                   stat;
  logic                   hit;

  assign hit = en && (count == cmp);

  // Hardware update first; software writes later in the block override it,
  // except a W1C of STAT never beats a simultaneous compare hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      cmp    <= '1;
      en     <= 1'b0;
      reload <= 1'b0;
      stat   <= 1'b0;
    end else begin
      if (en) begin
        if (!hit) begin
          count <= count + 1'b1;
        end else begin
          stat <= 1'b1;
          if (reload)
            count <= '0;
          else
            en <= 1'b0;
        end
      end
      if (we) begin
        case (reg_sel)
          TREG_COUNT: count <= writedata[TIMER_WIDTH-1:0];
          TREG_CMP:   cmp   <= writedata[TIMER_WIDTH-1:0];
          TREG_CTRL: begin
            en     <= writedata[EN_BIT];
            reload <= writedata[RELOAD_BIT];
            if (writedata[STAT_BIT] && !hit)
              stat <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    ctrl_rd             = '0;
    ctrl_rd[EN_BIT]     = en;
    ctrl_rd[RELOAD_BIT] = reload;
    ctrl_rd[STAT_BIT]   = stat;
  end

  assign count_rd  = 32'(count);
  assign cmp_rd    = 32'(cmp);
  assign timer_irq = stat;

endmodule
`default_nettype wire

// File: rtl/mem_io_bus.sv
// mem_io_bus: address decode, unified RAM, LED register and timer behind the multicycle core.
`default_nettype none
module mem_io_bus
  import mem_io_pkg::*;
#(
  parameter int RAM_WORDS   = 64,
  parameter int TIMER_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  output logic [7:0]  leds,
  output logic        timer_irq
);

  localparam int IDX_W = $clog2(RAM_WORDS);

  logic [31:0]      ram [RAM_WORDS];
  logic [IDX_W-1:0] ram_idx;
  sel_t             sel;
  logic [31:0]      count_rd;
  logic [31:0]      cmp_rd;
  logic [31:0]      ctrl_rd;
  logic             unused_byte_lanes;

  assign unused_byte_lanes = ^adr[1:0];

  assign sel     = decode(adr[31:2]);
  // Indices above RAM_WORDS alias by dropping the upper index bits
  assign ram_idx = adr[2 +: IDX_W];

  always_ff @(posedge clk) begin
    if (memwrite && sel == SEL_RAM)
      ram[ram_idx] <= writedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      leds <= 8'd0;
    else if (memwrite && sel == SEL_LEDS)
      leds <= writedata[7:0];
  end

  timer_unit #(
    .TIMER_WIDTH(TIMER_WIDTH)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .we       (memwrite && sel == SEL_TIMER),
    .reg_sel  (adr[3:2]),
    .writedata(writedata),
    .count_rd (count_rd),
    .cmp_rd   (cmp_rd),
    .ctrl_rd  (ctrl_rd),
    .timer_irq(timer_irq)
  );

  always_comb begin
    readdata = 32'd0;
    case (sel)
      SEL_RAM:  readdata = ram[ram_idx];
      SEL_LEDS: readdata = {24'd0, leds};
      SEL_TIMER: begin
        case (adr[3:2])
          TREG_COUNT: readdata = count_rd;
          TREG_CMP:   readdata = cmp_rd;
          TREG_CTRL:  readdata = ctrl_rd;
          default:    readdata = 32'd0;
        endcase
      end
      default: readdata = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_bus.sv
// tb_mem_io_bus: directed plus randomized stimulus, scoreboard checked against a behavioural model.
`default_nettype none
module tb_mem_io_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic [7:0]  leds;
  logic        timer_irq;

  mem_io_bus dut (
    .clk      (clk),
    .reset    (reset),
    .adr      (adr),
    .writedata(writedata),
    .memwrite (memwrite),
    .readdata (readdata),
    .leds     (leds),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;
  exp_t exp_q[$];
  logic rd_strobe = 1'b0;

  // Behavioural model state
  logic [31:0] m_ram [64];
  bit          m_valid [64];
  int          vlist[$];
  logic [7:0]  m_leds;
  logic [31:0] m_count, m_cmp;
  logic        m_en, m_reload, m_stat;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_leds = 8'd0; m_count = 32'd0; m_cmp = 32'hFFFF_FFFF;
    m_en = 1'b0; m_reload = 1'b0; m_stat = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (a[31:8] == 24'd0) return m_ram[a[7:2]];
    case (wa)
      32'hFFFF_0000: return {24'd0, m_leds};
      32'hFFFF_0004: return m_count;
      32'hFFFF_0008: return m_cmp;
      32'hFFFF_000C: return {29'd0, m_stat, m_reload, m_en};
      default:       return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic hit;
    hit = m_en && (m_count == m_cmp);
    if (m_en) begin
      if (!hit) m_count = m_count + 32'd1;
      else begin
        m_stat = 1'b1;
        if (m_reload) m_count = 32'd0;
        else m_en = 1'b0;
      end
    end
    if (w) begin
      if (a[31:8] == 24'd0) begin
        m_ram[a[7:2]] = d;
        if (!m_valid[a[7:2]]) begin
          m_valid[a[7:2]] = 1'b1;
          vlist.push_back(int'(a[7:2]));
        end
      end else begin
        case ({a[31:2], 2'b00})
          32'hFFFF_0000: m_leds = d[7:0];
          32'hFFFF_0004: m_count = d;
          32'hFFFF_0008: m_cmp = d;
          32'hFFFF_000C: begin
            m_en = d[0];
            m_reload = d[1];
            if (d[2] && !hit) m_stat = 1'b0;
          end
          default: ;
        endcase
      end
    end
  endtask

  // One bus cycle: drive after the edge, optionally queue a read expectation, commit at next edge
  task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input bit chk, input logic [31:0] exp, input string nm);
    adr = a; writedata = d; memwrite = w;
    if (chk) begin
      exp_q.push_back('{nm, exp});
      rd_strobe = 1'b1;
    end
    @(posedge clk);
    model_step(w, a, d);
    #1;
    memwrite = 1'b0;
    rd_strobe = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    op(1'b1, a, d, 1'b0, 32'd0, "");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    op(1'b0, a, 32'd0, 1'b1, exp, nm);
  endtask

  task automatic idle();
    op(1'b0, 32'h1000_0000, 32'd0, 1'b0, 32'd0, "");
  endtask

  // Monitor: compares outputs against the model and the queued read expectations
  always @(negedge clk) begin
    if (!reset) begin
      check("leds_vs_model", {24'd0, leds}, {24'd0, m_leds});
      check("irq_vs_model", {31'd0, timer_irq}, {31'd0, m_stat});
      if (rd_strobe) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL scoreboard_underflow: got read %h expected none queued", readdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check(e.nm, readdata, e.v);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, d;
    int r;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    model_reset();
    reset = 1'b1; adr = 32'd0; writedata = 32'd0; memwrite = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    rd(32'hFFFF_0000, 32'h0000_0000, "rst_leds");
    rd(32'hFFFF_0004, 32'h0000_0000, "rst_tcount");
    rd(32'hFFFF_0008, 32'hFFFF_FFFF, "rst_tcmp");
    rd(32'hFFFF_000C, 32'h0000_0000, "rst_tctrl");
    check("rst_leds_port", {24'd0, leds}, 32'd0);
    check("rst_irq", {31'd0, timer_irq}, 32'd0);

    // RAM and unmapped region
    wr(32'h0000_0010, 32'h1234_5678);
    wr(32'h0000_0110, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'h1234_5678, "ram_rd_10");
    rd(32'h0000_0110, 32'h0000_0000, "unmapped_110");
    wr(32'hFFFF_0010, 32'hCAFE_F00D);
    rd(32'hFFFF_0010, 32'h0000_0000, "unmapped_ffff0010");
    rd(32'h0000_0013, 32'h1234_5678, "ram_byte_offset_ignored");

    // LEDs
    wr(32'hFFFF_0000, 32'h0000_01A5);
    check("leds_a5", {24'd0, leds}, 32'h0000_00A5);
    rd(32'hFFFF_0000, 32'h0000_00A5, "leds_rd");

    // One-shot timer
    wr(32'hFFFF_0008, 32'd5);
    wr(32'hFFFF_000C, 32'h1);
    repeat (5) idle();
    check("oneshot_irq_before", {31'd0, timer_irq}, 32'd0);
    idle();
    check("oneshot_irq_6th_edge", {31'd0, timer_irq}, 32'd1);
    idle();
    rd(32'hFFFF_0004, 32'd5, "oneshot_count_holds");
    rd(32'hFFFF_000C, 32'h4, "oneshot_tctrl");
    wr(32'hFFFF_000C, 32'h4);
    check("oneshot_w1c_irq", {31'd0, timer_irq}, 32'd0);

    // Auto-reload
    wr(32'hFFFF_0004, 32'd0);
    wr(32'hFFFF_0008, 32'd2);
    wr(32'hFFFF_000C, 32'h3);
    rd(32'hFFFF_0004, 32'd0, "reload_seq0");
    rd(32'hFFFF_0004, 32'd1, "reload_seq1");
    rd(32'hFFFF_0004, 32'd2, "reload_seq2");
    check("reload_irq_first_wrap", {31'd0, timer_irq}, 32'd1);
    rd(32'hFFFF_0004, 32'd0, "reload_seq3");
    rd(32'hFFFF_0004, 32'd1, "reload_seq4");
    wr(32'hFFFF_000C, 32'h7);
    check("w1c_vs_set_irq", {31'd0, timer_irq}, 32'd1);
    rd(32'hFFFF_000C, 32'h7, "w1c_vs_set_tctrl");

    // Asynchronous reset mid-count
    wr(32'hFFFF_0008, 32'd10);
    wr(32'hFFFF_0004, 32'd3);
    adr = 32'hFFFF_0004;
    #1 check("pre_reset_count", readdata, 32'd3);
    reset = 1'b1;
    #1 check("async_rst_count", readdata, 32'd0);
    adr = 32'hFFFF_000C;
    #1 check("async_rst_tctrl", readdata, 32'd0);
    check("async_rst_irq", {31'd0, timer_irq}, 32'd0);
    model_reset();
    reset = 1'b0;
    repeat (3) idle();
    rd(32'hFFFF_0004, 32'd0, "no_count_after_reset");

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: wr({24'd0, 8'($urandom)}, $urandom);
        1: if (vlist.size() > 0) begin
             a = {24'd0, 6'(vlist[$urandom_range(0, vlist.size() - 1)]), 2'($urandom)};
             rd(a, m_read(a), "rnd_ram");
           end
        2: wr(32'hFFFF_0000 | 32'($urandom_range(0, 3)), $urandom);
        3: begin
             case ($urandom_range(1, 3))
               1: wr(32'hFFFF_0004, 32'($urandom_range(0, 6)));
               2: wr(32'hFFFF_0008, 32'($urandom_range(0, 6)));
               default: wr(32'hFFFF_000C, 32'($urandom_range(0, 7)));
             endcase
           end
        4, 5, 6: begin
             a = 32'hFFFF_0000 + 32'($urandom_range(0, 3) * 4);
             rd(a, m_read(a), "rnd_reg");
           end
        7: begin
             case ($urandom_range(0, 3))
               0: a = 32'hFFFF_0010;
               1: a = 32'h0000_0100 | 32'($urandom_range(0, 255));
               2: a = 32'hFFFF_0014;
               default: a = 32'h8000_0000;
             endcase
             if ($urandom_range(0, 1) == 1) wr(a, $urandom);
             else rd(a, m_read(a), "rnd_unmapped");
           end
        default: idle();
      endcase
    end

    repeat (2) idle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
